// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and the UART transmitter.
// The source drives data_in and in_valid; the transmitter answers with in_ready.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;

  modport master (output data_in, output in_valid, input in_ready);
  modport slave  (input data_in, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, with a one-entry holding register so frames can run back-to-back.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD) between data and stop.
module uart_tx #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 50000000,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave host,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);
  localparam int          BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST   = 16'(BIT_PERIOD - 1);

  if (BIT_PERIOD < 2 || BIT_PERIOD > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: BIT_PERIOD must be 2..65535 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_bit(input logic [7:0] data);
    return (^data) ^ 1'(PARITY_ODD);
  endfunction
`endif

  state_t      state_r;
  logic [7:0]  hold_r;
  logic        hold_full_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic [15:0] clk_cnt_r;
  logic        accept_s;
  logic        bit_end_s;

  assign host.in_ready = ~hold_full_r;
  assign accept_s      = host.in_valid & ~hold_full_r;
  assign bit_end_s     = (clk_cnt_r == BIT_LAST);

  // Holding register, frame sequencer and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      shift_r     <= 8'h00;
      bit_idx_r   <= 3'd0;
      clk_cnt_r   <= 16'd0;
    end else begin
      tx_done <= 1'b0;
      // A fill and a drain never share an edge: filling needs the hold empty, draining needs it full.
      if (accept_s) begin
        hold_r      <= host.data_in;
        hold_full_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          clk_cnt_r <= 16'd0;
          bit_idx_r <= 3'd0;
          if (hold_full_r) begin
            state_r     <= START;
            shift_r     <= hold_r;
            hold_full_r <= 1'b0;
            tx          <= 1'b0;
            busy        <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            clk_cnt_r <= 16'd0;
            tx        <= shift_r[0];
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              tx      <= parity_bit(shift_r);
`else
              state_r <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx        <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end_s) begin
            state_r   <= STOP;
            clk_cnt_r <= 16'd0;
            tx        <= 1'b1;
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end_s) begin
            tx_done   <= 1'b1;
            clk_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            // A waiting byte starts its frame on this very edge, leaving no idle clock.
            if (hold_full_r) begin
              state_r     <= START;
              shift_r     <= hold_r;
              hold_full_r <= 1'b0;
              tx          <= 1'b0;
            end else begin
              state_r <= IDLE;
              tx      <= 1'b1;
              busy    <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          tx        <= 1'b1;
          busy      <= 1'b0;
          clk_cnt_r <= 16'd0;
          bit_idx_r <= 3'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model checked every cycle, plus directed literal checks.
module tb_uart_tx;
  localparam int BP      = 10;
  localparam int TB_PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FR = NBITS * BP;

  logic clk;
  logic reset;
  logic tx, busy, tx_done;
  uart_tx_if uif();

  uart_tx #(.BAUD_RATE(100), .CLK_FREQ(1000), .PARITY_ODD(TB_PODD)) dut (
    .clk(clk), .reset(reset), .host(uif), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model: a frame is a list of line bits, each held BP clocks from the edge it starts on.
  int          e;
  int          m_t0;
  logic        m_active, m_hold_v, m_done;
  logic [7:0]  m_hold;
  logic [10:0] m_bits;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic offer(input logic [7:0] d);
    int t;
    t = 0;
    while (uif.in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("offer_timeout", 8'd0, 8'd1);
    uif.data_in  = d;
    uif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    uif.in_valid = 1'b0;
    uif.data_in  = ~d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [9:0] pat_a5;
  logic       exp_tx;
  logic       acc;

  initial begin
    n_cmp = 0; n_bad = 0; e = 0; m_t0 = 0;
    m_active = 1'b0; m_hold_v = 1'b0; m_done = 1'b0; m_hold = 8'h00; m_bits = '1;
    reset = 1'b0; uif.in_valid = 1'b0; uif.data_in = 8'h00;
    pat_a5 = 10'b1101001010;

    fork
      forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
          m_active = 1'b0; m_hold_v = 1'b0; m_done = 1'b0;
        end else begin
          e++;
          acc    = uif.in_valid && !m_hold_v;
          m_done = 1'b0;
          if (m_active && e == m_t0 + FR) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
          if (!m_active && m_hold_v) begin
            m_active = 1'b1;
            m_t0     = e;
            m_bits   = {1'b1, (^m_hold) ^ 1'(TB_PODD), m_hold, 1'b0};
            if (NBITS == 10) m_bits[9] = 1'b1;
            m_hold_v = 1'b0;
          end
          if (acc) begin
            m_hold_v = 1'b1;
            m_hold   = uif.data_in;
          end
        end
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
          chk("rst_done", tx_done, 0); chk("rst_ready", uif.in_ready, 1);
        end else begin
          exp_tx = m_active ? m_bits[(e - m_t0) / BP] : 1'b1;
          chk("tx", tx, exp_tx);
          chk("busy", busy, m_active);
          chk("tx_done", tx_done, m_done);
          chk("in_ready", uif.in_ready, !m_hold_v);
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset held with in_valid toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      uif.in_valid = ~uif.in_valid;
      uif.data_in  = 8'(i);
    end
    @(negedge clk);
    uif.in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("ready_after_rst", uif.in_ready, 1);
    chk("idle_tx", tx, 1);
    repeat (3) step();

    // Single byte 0xA5
    offer(8'hA5);
    chk("a5_k", tx, 1);
    for (int j = 1; j <= FR + 5; j++) begin
      step();
      if (j == 1) chk("a5_start", tx, 0);
      if ((j - 1) % BP == 5 && (j - 1) / BP <= 8) chk("a5_bit", tx, pat_a5[(j - 1) / BP]);
      if (j == FR - 4) chk("a5_stop", tx, 1);
      if (j == FR) chk("a5_done_early", tx_done, 0);
      if (j == FR + 1) begin chk("a5_done", tx_done, 1); chk("a5_busy_after", busy, 0); end
      if (j == FR + 2) chk("a5_done_once", tx_done, 0);
    end

    // Back-to-back 0x55 then 0x0F
    offer(8'h55);
    for (int j = 1; j <= 2 * FR + 5; j++) begin
      step();
      if (j == 20) begin uif.data_in = 8'h0F; uif.in_valid = 1'b1; end
      if (j == 21) begin uif.in_valid = 1'b0; chk("b2b_ready_low", uif.in_ready, 0); end
      if (j == FR) chk("b2b_stop", tx, 1);
      if (j == FR + 1) begin chk("b2b_start2", tx, 0); chk("b2b_done1", tx_done, 1); chk("b2b_ready_back", uif.in_ready, 1); end
      if (j == FR + 16) chk("b2b_0f_bit0", tx, 1);
      if (j == FR + 56) chk("b2b_0f_bit4", tx, 0);
      if (j == 2 * FR + 1) begin chk("b2b_done2", tx_done, 1); chk("b2b_busy_end", busy, 0); end
    end

    // Backpressure: third byte offered while hold is full
    offer(8'h11);
    for (int j = 1; j <= 3 * FR + 5; j++) begin
      step();
      if (j == 5) begin uif.data_in = 8'h22; uif.in_valid = 1'b1; end
      if (j == 6) uif.data_in = 8'h33;
      if (j == 50) chk("bp_ready_low", uif.in_ready, 0);
      if (j == FR + 1) chk("bp_drained", uif.in_ready, 1);
      if (j == FR + 2) begin chk("bp_third_taken", uif.in_ready, 0); uif.in_valid = 1'b0; end
      if (j == 2 * FR + 16) chk("bp_33_bit0", tx, 1);
      if (j == 2 * FR + 36) chk("bp_33_bit2", tx, 0);
      if (j == 3 * FR + 1) chk("bp_done3", tx_done, 1);
    end

    // Reset during data bit 3, then a fresh 0x3C
    offer(8'h96);
    for (int j = 1; j <= 45; j++) step();
    #2 reset = 1'b0;
    #1 chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    chk("mid_rst_ready", uif.in_ready, 1);
    offer(8'h3C);
    for (int j = 1; j <= FR + 3; j++) begin
      step();
      if (j == 1) chk("3c_start", tx, 0);
      if (j == 16) chk("3c_bit0", tx, 0);
      if (j == 36) chk("3c_bit2", tx, 1);
      if (j == 86) chk("3c_bit7", tx, 0);
      if (j == FR + 1) chk("3c_done", tx_done, 1);
    end

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    offer(8'h07);
    for (int j = 1; j <= FR + 3; j++) begin
      step();
      if (j == 96) chk("par_07", tx, (TB_PODD != 0) ? 8'd0 : 8'd1);
      if (j == 106) chk("par_stop", tx, 1);
      if (j == 110) chk("par_not_done", tx_done, 0);
      if (j == 111) chk("par_done_110", tx_done, 1);
    end
`endif

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
